divider_32bits: RTL and testbench
=================================

# divider_32bits

Multi-cycle 32-bit integer divider for the integer ALU calculation path. It accepts a dividend/divisor pair on a start pulse and produces quotient and remainder after a fixed 34-cycle latency. One restoring-division step runs per cycle, and each trial subtraction goes through the existing 32-bit adder/subtractor instance, which is driven with subtract control tied high. The block drives that adder's operands and consumes its sum and carry-out.

## Interface
Parameters:
- size, 32, operand width. Only 32 is supported; the adder instance is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- sign  input  1  1 = signed (two's complement), 0 = unsigned; captured with start
- A  input  [size:1]  dividend; captured with start
- B  input  [size:1]  divisor; captured with start
- busy  output  1  high from the cycle after an accepted start through the FIX state
- done  output  1  one-cycle pulse; Q, R, DivZero and Ovf are valid from this cycle on
- Q  output  [size:1]  quotient; held until the next done
- R  output  [size:1]  remainder; held until the next done
- DivZero  output  1  B was zero for the completed operation
- Ovf  output  1  signed -2^31 / -1 for the completed operation

## Operation
- States and transitions:
  - IDLE: start=1 → CALC
  - CALC: after 32 steps → FIX
  - FIX: → DONE
  - DONE: → IDLE
- Capture on an accepted start:
  - sign and the divisor-zero / overflow conditions are latched.
  - Operands are converted to magnitudes. When sign=1, a negative operand is negated (0x80000000 stays 0x80000000 as unsigned).
  - Partial remainder P=0, working quotient W=|A|, step counter=0.
- Each CALC step:
  - Form T = {P[31:1], W[32]}, i.e. the remainder shifted left with the next dividend bit.
  - Drive the adder with A=T, B=|B|, Ctr=1.
  - Quotient bit qb = P[32] | Co. P[32] is the bit shifted out and makes the partial remainder 33 bits wide; Co=1 means no borrow.
  - If qb=1, P becomes the adder sum S; otherwise P becomes T.
  - W shifts left with qb entering at bit 1.
  - The counter increments; the 32nd step exits to FIX.
- FIX:
  - Unsigned: Q=W, R=P.
  - Signed: Q is negated if sign(A)≠sign(B), and R takes the sign of A (truncating division).
  - DivZero overrides: Q=0xFFFFFFFF, R=A as captured (raw, not the magnitude). Ovf=0 in this case.
  - Ovf (sign=1, A=0x80000000, B=0xFFFFFFFF) gives Q=0x80000000 and R=0.
  - Q, R and both flags are registered at the FIX→DONE edge.
- DONE: done=1 for one cycle, busy=0.
- start in any state other than IDLE is ignored, with no queuing. A start in the DONE cycle is also ignored; IDLE must be reached first.
- The adder's overflow output Cy is unused.

## Timing
- Reset value of every output is 0: busy, done, Q, R, DivZero, Ovf. State resets to IDLE and the counter to 0.
- An rst_n assertion mid-operation aborts immediately (asynchronously): outputs go to 0 and no done is produced. After release the block is in IDLE and ready for start on the first edge.
- Let edge 0 be the edge that samples start=1 in IDLE. Then:
  - busy=1 after edges 0..33.
  - CALC steps occur on edges 1..32.
  - FIX is at edge 33.
  - done=1 for the single cycle after edge 34.
  - Total latency is 34 cycles from start to done, regardless of operand values.
- The next start can be sampled at edge 35 at the earliest, giving throughput of one operation per 35 cycles.
- The adder sits on the combinational path P/W → adder → P within a single cycle. This is a full 32-bit ripple path, and the clock constraint must accommodate it.

## Test plan
- Unsigned, sign=0, A=100, B=7, start → done exactly 34 cycles later; Q=14, R=2, DivZero=0, Ovf=0.
- Unsigned large divisor, A=0xFFFFFFFF, B=0x80000001 → Q=1, R=0x7FFFFFFE. This exercises the P[32]=1 path.
- Signed, sign=1, A=-7 (0xFFFFFFF9), B=2 → Q=-3 (0xFFFFFFFD), R=-1 (0xFFFFFFFF). Also A=7, B=-2 → Q=0xFFFFFFFD, R=1.
- Edge cases:
  - B=0 with A=0x12345678 (either sign mode) → Q=0xFFFFFFFF, R=0x12345678, DivZero=1.
  - sign=1, A=0x80000000, B=0xFFFFFFFF → Q=0x80000000, R=0, Ovf=1.
- Handshake:
  - start held high for the whole operation → exactly one done, with no restart until after IDLE.
  - A second start with different operands at cycle 10 → ignored; results match the first operands.
- Reset mid-operation: rst_n low at cycle 15 → all outputs 0 immediately, no done. After release, a new operation with A=9, B=3 → Q=3, R=0 at 34 cycles.

Source files
------------

// File: rtl/divider_32bits.sv
// Purpose: multi-cycle 32-bit restoring divider (signed/unsigned) with quotient and remainder.
// Latency: fixed 34 cycles from the start edge to the done pulse, one operation per 35 cycles.
// Backpressure: none; start is sampled only in IDLE, and any other start is dropped without queuing.
//
// Ports: clk/rst_n (async active-low); start, sign, A, B request inputs;
//        busy, done status; Q, R, DivZero, Ovf results held until the next done.

// 32-bit adder/subtractor: Ctr=1 computes A - B, and Co=1 then means no borrow.
module adder_32bits (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Ctr,
    output logic [31:0] S,
    output logic        Co,
    output logic        Cy
);
    logic [31:0] b_x;
    logic [32:0] sum;

    always_comb begin
        b_x = B ^ {32{Ctr}};
        sum = {1'b0, A} + {1'b0, b_x} + {32'd0, Ctr};
        S   = sum[31:0];
        Co  = sum[32];
        // Two's-complement overflow of the signed interpretation.
        Cy  = (A[31] == b_x[31]) && (sum[31] != A[31]);
    end
endmodule

module divider_32bits #(
    parameter int size = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sign,
    input  logic [size:1] A,
    input  logic [size:1] B,
    output logic          busy,
    output logic          done,
    output logic [size:1] Q,
    output logic [size:1] R,
    output logic          DivZero,
    output logic          Ovf
);
    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX, ST_DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] p_q, p_d;          // partial remainder
    logic [31:0] w_q, w_d;          // dividend bits shifting out, quotient bits shifting in
    logic [31:0] bmag_q, bmag_d;
    logic [31:0] araw_q, araw_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dz_q, dz_d;
    logic        ov_q, ov_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        div_zero_q, div_zero_d;
    logic        ovf_q, ovf_d;

    logic [31:0] a_mag, b_mag, t_val;
    logic [31:0] add_s;
    logic        add_co, add_cy_unused, qb;

    always_comb begin
        a_mag = (sign && A[size]) ? (~A + 32'd1) : A;
        b_mag = (sign && B[size]) ? (~B + 32'd1) : B;
        // Remainder shifted left with the next dividend bit; p_q[31] is the
        // bit shifted out and acts as the 33rd remainder bit.
        t_val = {p_q[30:0], w_q[31]};
    end

    adder_32bits u_add (
        .A   (t_val),
        .B   (bmag_q),
        .Ctr (1'b1),
        .S   (add_s),
        .Co  (add_co),
        .Cy  (add_cy_unused)
    );

    // A set 33rd bit means the shifted remainder certainly exceeds the divisor.
    assign qb = p_q[31] | add_co;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        w_d        = w_q;
        bmag_d     = bmag_q;
        araw_d     = araw_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        q_d        = q_q;
        r_d        = r_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    cnt_d   = 5'd0;
                    p_d     = 32'd0;
                    w_d     = a_mag;
                    bmag_d  = b_mag;
                    araw_d  = A;
                    qneg_d  = sign && (A[size] ^ B[size]);
                    rneg_d  = sign && A[size];
                    dz_d    = (B == 32'd0);
                    ov_d    = sign && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
                end
            end
            ST_CALC: begin
                p_d   = qb ? add_s : t_val;
                w_d   = {w_q[30:0], qb};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                if (dz_q) begin
                    q_d        = 32'hFFFF_FFFF;
                    r_d        = araw_q;
                    div_zero_d = 1'b1;
                    ovf_d      = 1'b0;
                end else if (ov_q) begin
                    q_d        = 32'h8000_0000;
                    r_d        = 32'd0;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b1;
                end else begin
                    // Truncating division: remainder follows the dividend's sign.
                    q_d        = qneg_q ? (~w_q + 32'd1) : w_q;
                    r_d        = rneg_q ? (~p_q + 32'd1) : p_q;
                    div_zero_d = 1'b0;
                    ovf_d      = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy covers CALC, FIX and DONE states; done is a registered pulse
        // that follows the DONE state by one cycle.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            p_q        <= 32'd0;
            w_q        <= 32'd0;
            bmag_q     <= 32'd0;
            araw_q     <= 32'd0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            q_q        <= 32'd0;
            r_q        <= 32'd0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            w_q        <= w_d;
            bmag_q     <= bmag_d;
            araw_q     <= araw_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            q_q        <= q_d;
            r_q        <= r_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = div_zero_q;
    assign Ovf     = ovf_q;
endmodule

// File: tb/tb_divider_32bits.sv
// Purpose: randomized and directed checking of divider_32bits against an arithmetic model.
// Latency: expects done exactly 34 cycles after the start edge.
// Backpressure: exercises held and mid-operation starts, which must be ignored.
module tb_divider_32bits;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy;
    logic        done;
    logic [31:0] q_o;
    logic [31:0] r_o;
    logic        div_zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    divider_32bits #(.size(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sign    (sign),
        .A       (a_i),
        .B       (b_i),
        .busy    (busy),
        .done    (done),
        .Q       (q_o),
        .R       (r_o),
        .DivZero (div_zero),
        .Ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Plain-arithmetic reference: truncating signed division, with the
    // divide-by-zero and -2^31/-1 cases defined explicitly.
    task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output bit dz, output bit ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            ov = 1'b1;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // One operation; hold keeps start high until done, inj_at (>0) pulses a
    // conflicting start with different operands at that cycle.
    task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int inj_at);
        logic [31:0] eq, er;
        bit edz, eov, seen;
        int n, dones;
        model(s, a, b, eq, er, edz, eov);
        @(negedge clk);
        start = 1'b1;
        sign  = s;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        n = 0;
        dones = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (n == inj_at) begin
                start = 1'b1;
                sign  = ~s;
                a_i   = a ^ 32'h5A5A_A5A5;
                b_i   = b + 32'd3;
            end else if (n == inj_at + 1 && !hold) begin
                start = 1'b0;
            end
            if (n == 1) chk_eq("busy_first", {31'd0, busy}, 32'd1);
            if (n == 33) chk_eq("busy_last", {31'd0, busy}, 32'd1);
            if (done) begin
                seen = 1'b1;
                dones++;
            end
        end
        start = 1'b0;
        chk_eq("latency", n, 32'd34);
        chk_eq("quotient", q_o, eq);
        chk_eq("remainder", r_o, er);
        chk_eq("divzero", {31'd0, div_zero}, {31'd0, edz});
        chk_eq("ovf", {31'd0, ovf}, {31'd0, eov});
        chk_eq("busy_at_done", {31'd0, busy}, 32'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk_eq("one_done", dones, 32'd1);
        chk_eq("idle_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dn;
        logic [31:0] ra, rb;
        bit rs;
        rst_n = 1'b0;
        start = 1'b0;
        sign  = 1'b0;
        a_i   = 32'd0;
        b_i   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_done", {31'd0, done}, 32'd0);
        chk_eq("rst_q", q_o, 32'd0);
        chk_eq("rst_r", r_o, 32'd0);
        chk_eq("rst_flags", {30'd0, div_zero, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        do_op(1'b0, 32'd100, 32'd7, 1'b0, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        do_op(1'b0, 32'h1234_5678, 32'd0, 1'b0, 0);
        do_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op(1'b1, 32'h8000_0000, 32'd1, 1'b0, 0);
        // Handshake: held start, and a conflicting start at cycle 10.
        do_op(1'b0, 32'd1000, 32'd33, 1'b1, 0);
        do_op(1'b1, 32'hFFFF_FC18, 32'd13, 1'b0, 10);

        // Mid-operation reset: results from the previous op are nonzero.
        @(negedge clk);
        start = 1'b1;
        sign  = 1'b0;
        a_i   = 32'd5000;
        b_i   = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("abort_busy", {31'd0, busy}, 32'd0);
        chk_eq("abort_done", {31'd0, done}, 32'd0);
        chk_eq("abort_q", q_o, 32'd0);
        chk_eq("abort_r", r_o, 32'd0);
        chk_eq("abort_flags", {30'd0, div_zero, ovf}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (done || busy) dn++;
        end
        chk_eq("abort_quiet", dn, 32'd0);
        do_op(1'b0, 32'd9, 32'd3, 1'b0, 0);

        // Randomized operations, biased toward small and zero divisors.
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: begin
                    rb = $urandom_range(0, 20);
                    if (rs && $urandom_range(0, 1) == 1) rb = ~rb + 32'd1;
                end
                1: ra = $urandom_range(0, 200);
                2: rb = rb >> $urandom_range(0, 31);
                default: ;
            endcase
            do_op(rs, ra, rb, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
